account_bank_arbiter: RTL and testbench
=======================================

// Module: account_bank_arbiter
// PURPOSE
//  Shares one account-balance store between NUM_REQ ATM front-end FSMs.
//  Round-robin arbitration; each granted transaction runs read-check-modify-write
//  atomically. The store is an internal register array.
//  Returns the resulting balance and an error flag to the requester; it sits
//  between the ATM FSMs and the balance store.
// PARAMETERS
//  NUM_REQ        2    number of ATM requesters (>=2)
//  BALANCE_WIDTH  20   balance/value width, unsigned
//  ACCT_WIDTH     4    account index width; 2**ACCT_WIDTH accounts
//  INIT_BALANCE   1000 reset value of every account
// PORTS
//  clk           in   1                      rising-edge clock
//  rst           in   1                      synchronous, active-high reset
//  req           in   NUM_REQ                per-requester request, level, hold until grant
//  req_op        in   2*NUM_REQ              per req: 00 withdraw, 01 deposit, 10 inquiry, 11 illegal
//  req_acct      in   ACCT_WIDTH*NUM_REQ     per req account index
//  req_value     in   BALANCE_WIDTH*NUM_REQ  per req amount (ignored for inquiry)
//  grant         out  NUM_REQ                one-hot, 1-cycle pulse: request captured
//  done          out  NUM_REQ                one-hot, 1-cycle pulse: result valid
//  resp_balance  out  BALANCE_WIDTH          account balance after the transaction
//  resp_error    out  1                      1 = rejected, store unchanged
//  busy          out  1                      1 in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; grant=0, done=0, resp_balance=0, resp_error=0, busy=0.
//   Every account = INIT_BALANCE; rr pointer = NUM_REQ-1, so req[0] wins first.
//  Reset mid-transaction aborts the transaction: no write-back, no done.
//  FSM: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE. Each state lasts one cycle.
//  IDLE: if any req bit is high, pick the winner round-robin.
//   Search starts at index ptr+1 and wraps. At the edge, latch the winner id, op, acct
//   and value, set ptr = winner, and go to READ. If no req, stay in IDLE.
//  READ: grant[winner]=1. Latch bal = store[acct].
//  EXEC: compute the result; unsigned arithmetic, BALANCE_WIDTH+1 bit sum.
//   withdraw: value > bal -> err; else new = bal - value (value == bal is legal -> 0).
//   deposit: bal + value carries out of BALANCE_WIDTH -> err; else new = bal + value.
//   inquiry: new = bal, err = 0. op 11: err = 1.
//  WRITE: store[acct] = new only if !err and op is withdraw or deposit.
//  DONE: done[winner]=1. resp_balance = err ? bal : new; resp_error = err.
//   Both hold until the next DONE. Then return to IDLE.
//  Latency: req seen in IDLE at cycle T -> grant at T+1 -> done at T+4.
//   Back-to-back throughput is one transaction per 5 cycles.
//  A requester must drop req after its grant. A req still high in IDLE starts a new transaction.
//  Requests arriving while busy wait; none are lost or queued beyond the level on req.
//  Simultaneous requests to the same account serialise, so the second one sees the first one's write.
//  A winner that drops req after IDLE still completes.
//  Only one bit of grant/done is ever high. busy = state != IDLE.
// TESTING
//  1 Reset, then req[0] withdraw 300 on acct 3 -> grant[0] @T+1, done[0] @T+4, resp 700, err 0.
//  2 req[0] and req[1] high together on the same cycle -> req[0] served first, req[1] next.
//    Repeated: service alternates 0,1,0,1 (round-robin fairness).
//  3 Withdraw 1001 from an account holding 1000 -> resp_error=1, resp 1000, store unchanged.
//    Withdraw 1000 -> resp 0.
//  4 Deposit 2**20-1000 into an account holding 1000 -> overflow, err 1, resp 1000.
//    Deposit 5 -> resp 1005.
//  5 Both requesters deposit 100 to acct 7 at the same time -> responses 1100 then 1200.
//    Inquiry -> 1200.
//  6 Assert rst in the EXEC state of a withdraw -> no done pulse, all outputs 0, acct = INIT_BALANCE.
//    op 11 -> err 1.

Source files
------------

// File: rtl/account_bank_arbiter_if.sv
// Bundle between the ATM front-end FSMs and the shared balance-store arbiter.
// No latency of its own. Signals only carry data between the two sides.
// Backpressure: a requester holds its req level until it sees its grant pulse.
interface account_bank_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int BALANCE_WIDTH = 20,
    parameter int ACCT_WIDTH    = 4
);
    logic [NUM_REQ-1:0]               req;
    logic [2*NUM_REQ-1:0]             req_op;
    logic [ACCT_WIDTH*NUM_REQ-1:0]    req_acct;
    logic [BALANCE_WIDTH*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0]               done;
    logic [BALANCE_WIDTH-1:0]         resp_balance;
    logic                             resp_error;
    logic                             busy;

    // ATM side: drives requests and observes results.
    modport master (
        output req, req_op, req_acct, req_value,
        input  grant, done, resp_balance, resp_error, busy
    );

    // Arbiter side: observes requests and drives results.
    modport slave (
        input  req, req_op, req_acct, req_value,
        output grant, done, resp_balance, resp_error, busy
    );
endinterface

// File: rtl/account_bank_arbiter.sv
// Round-robin arbiter giving NUM_REQ ATM FSMs atomic read-check-modify-write access to a balance store.
// Latency: req seen in IDLE at edge T -> grant visible after T, done 3 cycles after grant; 5 cycles per transaction.
// Backpressure: losers keep req high and wait; only the level on req is remembered, nothing is queued.
module account_bank_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int BALANCE_WIDTH = 20,
    parameter int ACCT_WIDTH    = 4,
    parameter int INIT_BALANCE  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    account_bank_arbiter_if.slave bus
);
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_ACCT = 2 ** ACCT_WIDTH;

    localparam logic [1:0] OP_WD  = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_INQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [IDW-1:0]           ptr_q;
    logic [IDW-1:0]           win_q, win_d;
    logic [1:0]               op_q;
    logic [ACCT_WIDTH-1:0]    acct_q;
    logic [BALANCE_WIDTH-1:0] val_q;
    logic [BALANCE_WIDTH-1:0] bal_q;
    logic [BALANCE_WIDTH-1:0] new_q, new_d;
    logic                     err_q, err_d;
    logic [BALANCE_WIDTH-1:0] resp_bal_q;
    logic                     resp_err_q;
    logic                     any_req;
    logic [BALANCE_WIDTH:0]   sum;

    logic [BALANCE_WIDTH-1:0] store_q [NUM_ACCT];

    // Per-requester views of the packed request fields.
    logic [1:0]               op_arr   [NUM_REQ];
    logic [ACCT_WIDTH-1:0]    acct_arr [NUM_REQ];
    logic [BALANCE_WIDTH-1:0] val_arr  [NUM_REQ];

    // Unpack the flat request buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i]   = bus.req_op[2*i +: 2];
            acct_arr[i] = bus.req_acct[ACCT_WIDTH*i +: ACCT_WIDTH];
            val_arr[i]  = bus.req_value[BALANCE_WIDTH*i +: BALANCE_WIDTH];
        end
    end

    // Round-robin pick (search starts after the last winner) and FSM next state.
    always_comb begin
        logic found;
        int   idx;
        state_d = state_q;
        win_d   = win_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                win_d = IDW'(idx);
            end
        end
        any_req = found;
        case (state_q)
            S_IDLE:  if (found) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Balance check and update; the extra sum bit catches deposit overflow.
    always_comb begin
        sum   = {1'b0, bal_q} + {1'b0, val_q};
        new_d = bal_q;
        err_d = 1'b0;
        case (op_q)
            OP_WD: begin
                if (val_q > bal_q) err_d = 1'b1;
                else               new_d = bal_q - val_q;
            end
            OP_DEP: begin
                if (sum[BALANCE_WIDTH]) err_d = 1'b1;
                else                    new_d = sum[BALANCE_WIDTH-1:0];
            end
            OP_INQ:  new_d = bal_q;
            default: err_d = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Transaction datapath: capture request, read, compute, publish response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= IDW'(NUM_REQ - 1);
            win_q      <= '0;
            op_q       <= '0;
            acct_q     <= '0;
            val_q      <= '0;
            bal_q      <= '0;
            new_q      <= '0;
            err_q      <= 1'b0;
            resp_bal_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        win_q  <= win_d;
                        ptr_q  <= win_d;
                        op_q   <= op_arr[win_d];
                        acct_q <= acct_arr[win_d];
                        val_q  <= val_arr[win_d];
                    end
                end
                S_READ: bal_q <= store_q[acct_q];
                S_EXEC: begin
                    new_q <= new_d;
                    err_q <= err_d;
                end
                S_WRITE: begin
                    resp_bal_q <= err_q ? bal_q : new_q;
                    resp_err_q <= err_q;
                end
                default: ;
            endcase
        end
    end

    // Balance store; only successful withdraws and deposits write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ACCT; a++) store_q[a] <= BALANCE_WIDTH'(INIT_BALANCE);
        end else if (state_q == S_WRITE && !err_q && (op_q == OP_WD || op_q == OP_DEP)) begin
            store_q[acct_q] <= new_q;
        end
    end

    // One-hot grant/done pulses and held response outputs.
    always_comb begin
        bus.grant        = '0;
        bus.done         = '0;
        bus.grant[win_q] = (state_q == S_READ);
        bus.done[win_q]  = (state_q == S_DONE);
        bus.resp_balance = resp_bal_q;
        bus.resp_error   = resp_err_q;
        bus.busy         = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_account_bank_arbiter.sv
// Directed bench for account_bank_arbiter with hand-computed expected results.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait for grant is bounded; a timeout shows up as a failed grant check.
module tb_account_bank_arbiter;
    localparam logic [1:0] WD  = 2'b00;
    localparam logic [1:0] DEP = 2'b01;
    localparam logic [1:0] INQ = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    account_bank_arbiter_if #(.NUM_REQ(2), .BALANCE_WIDTH(20), .ACCT_WIDTH(4)) bus ();

    account_bank_arbiter #(
        .NUM_REQ(2), .BALANCE_WIDTH(20), .ACCT_WIDTH(4), .INIT_BALANCE(1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic post(input int id, input logic [1:0] op, input logic [3:0] acct,
                        input logic [19:0] v);
        bus.req_op[2*id +: 2]     = op;
        bus.req_acct[4*id +: 4]   = acct;
        bus.req_value[20*id +: 20] = v;
        bus.req[id]               = 1'b1;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (bus.grant == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Waits for requester id to be granted, then checks the done pulse and response.
    task automatic serve(input string tag, input int id, input logic [19:0] eb,
                         input logic eerr, output int lat);
        wait_grant(lat);
        check({tag, "_grant"}, bus.grant, 32'(1 << id));
        check({tag, "_busy"}, bus.busy, 1);
        bus.req[id] = 1'b0;
        @(negedge clk);
        check({tag, "_nodone_exec"}, bus.done, 0);
        @(negedge clk);
        check({tag, "_nodone_write"}, bus.done, 0);
        @(negedge clk);
        check({tag, "_done"}, bus.done, 32'(1 << id));
        check({tag, "_bal"}, bus.resp_balance, eb);
        check({tag, "_err"}, bus.resp_error, eerr);
    endtask

    initial begin
        int lat;
        logic [1:0] seen_done;
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_acct  = '0;
        bus.req_value = '0;
        do_reset();

        // Reset state.
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_bal", bus.resp_balance, 0);
        check("rst_err", bus.resp_error, 0);
        check("rst_busy", bus.busy, 0);

        // 1: single withdraw, grant one cycle after request seen.
        post(0, WD, 4'd3, 20'd300);
        serve("t1", 0, 20'd700, 1'b0, lat);
        check("t1_lat", lat, 1);
        @(negedge clk);
        check("t1_idle", bus.busy, 0);
        check("t1_hold_bal", bus.resp_balance, 700);

        // 2: simultaneous requests from reset alternate 0,1,0,1.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            post(0, INQ, 4'd3, 20'd0);
            post(1, INQ, 4'd5, 20'd0);
            serve("t2_a", 0, 20'd1000, 1'b0, lat);
            serve("t2_b", 1, 20'd1000, 1'b0, lat);
        end

        // 3: withdraw boundaries.
        post(0, WD, 4'd1, 20'd1001);
        serve("t3_over", 0, 20'd1000, 1'b1, lat);
        post(0, INQ, 4'd1, 20'd0);
        serve("t3_inq", 0, 20'd1000, 1'b0, lat);
        post(0, WD, 4'd1, 20'd1000);
        serve("t3_exact", 0, 20'd0, 1'b0, lat);

        // 4: deposit overflow (1000 + 1047576 = 2**20) and a normal deposit.
        post(1, DEP, 4'd2, 20'd1047576);
        serve("t4_ovf", 1, 20'd1000, 1'b1, lat);
        post(1, DEP, 4'd2, 20'd5);
        serve("t4_dep", 1, 20'd1005, 1'b0, lat);

        // 5: same-account deposits serialise.
        do_reset();
        post(0, DEP, 4'd7, 20'd100);
        post(1, DEP, 4'd7, 20'd100);
        serve("t5_first", 0, 20'd1100, 1'b0, lat);
        serve("t5_second", 1, 20'd1200, 1'b0, lat);
        post(0, INQ, 4'd7, 20'd0);
        serve("t5_inq", 0, 20'd1200, 1'b0, lat);

        // 6: reset in EXEC aborts the withdraw.
        post(0, WD, 4'd4, 20'd500);
        wait_grant(lat);
        check("t6_grant", bus.grant, 1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_grant", bus.grant, 0);
        check("t6_rst_bal", bus.resp_balance, 0);
        check("t6_rst_err", bus.resp_error, 0);
        check("t6_rst_busy", bus.busy, 0);
        seen_done = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check("t6_no_done", seen_done, 0);
        post(0, INQ, 4'd4, 20'd0);
        serve("t6_inq", 0, 20'd1000, 1'b0, lat);
        post(1, ILL, 4'd4, 20'd10);
        serve("t6_ill", 1, 20'd1000, 1'b1, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
